prescaler_ctrl: RTL

- Run-time programmable clock prescaler with a sequencing controller around the divide counter.
- Adds a valid/ready configuration port, start/stop control, and burst mode (emit N output periods, then halt).
- Divisor changes are glitch-free: they apply only at a period boundary.
- Drives a divided clock level plus a single-cycle tick enable for downstream timers and serial engines.

---
 rtl/prescaler_pkg.sv | 27 ++
 rtl/prescaler_core.sv | 62 ++++++
 rtl/prescaler_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/prescaler_pkg.sv
// ---------------------------------------------------------------------------
// prescaler_pkg
//   Shared definitions for the programmable clock prescaler:
//   controller state encoding, default widths and the divisor helper.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prescaler_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int BURST_W_DEF = 8;

  // Controller states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RUN      = 2'd1;
  localparam state_t ST_STOPPING = 2'd2;

  // A programmed half-period of 0 behaves exactly like 1.
  function automatic int unsigned eff_div(input int unsigned div);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prescaler_core.sv
// ---------------------------------------------------------------------------
// prescaler_core
//   Half-period counter and divided-clock toggle.
//   Ports:
//     clk_in   - system clock
//     reset_n  - synchronous active-low reset
//     en       - count enable
//     clear    - force counter and clk_out to 0, suppress tick (wins over en)
//     div      - effective half-period (must be non-zero)
//     clk_out  - registered divided clock level
//     tick     - registered pulse in the cycle clk_out has just become 1
//     rise     - this edge will toggle clk_out 0->1
//     fall     - this edge will toggle clk_out 1->0
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prescaler_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             rise,
  output logic             fall
);

  logic [CNT_W-1:0] count;
  logic             tc;

  // Terminal count: the counter never runs past div-1, so it cannot wrap.
  assign tc   = en && (count == (div - CNT_W'(1)));
  assign rise = tc && !clk_out;
  assign fall = tc &&  clk_out;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= rise;
      if (tc) begin
        count   <= '0;
        clk_out <= ~clk_out;
      end else if (en) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/prescaler_ctrl.sv
// ---------------------------------------------------------------------------
// prescaler_ctrl
//   Run-time programmable clock prescaler with start/stop sequencing,
//   burst mode and glitch-free divisor updates at period boundaries.
//   Ports:
//     clk_in, reset_n      - clock, synchronous active-low reset
//     cfg_valid/cfg_ready  - configuration handshake
//     cfg_div              - half-period in clk_in cycles (0 acts as 1)
//     cfg_burst            - clk_out rising edges per run (0 = continuous)
//     start, stop          - level-sampled run control (stop wins)
//     clk_out              - divided clock level
//     tick                 - one-cycle pulse with each clk_out rise
//     busy                 - controller not idle
//     done                 - one-cycle pulse on return to idle
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prescaler_ctrl
  import prescaler_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   active_div;
  logic [BURST_W-1:0] active_burst;
  logic [CNT_W-1:0]   shadow_div;
  logic [BURST_W-1:0] shadow_burst;
  logic               pending;
  logic [BURST_W-1:0] burst_cnt;
  logic               armed;
  logic [CNT_W-1:0]   div_eff;
  logic               core_en;
  logic               core_clear;
  logic               rise;
  logic               fall;
  logic               burst_hit;
  logic               leave_run;

  assign div_eff   = CNT_W'(eff_div(32'(active_div)));
  assign cfg_ready = !pending;
  assign busy      = (state != ST_IDLE);
  assign burst_hit = (active_burst != '0) && (burst_cnt == active_burst);

  // The first cycle in RUN is spent arming the counter, which puts the first
  // clk_out rise D+1 cycles after start is sampled.
  assign core_en = armed && (state != ST_IDLE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start && !stop) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          // A high phase is never cut short: finish it in STOPPING unless it
          // is ending on this very edge.
          if (!clk_out || fall) next_state = ST_IDLE;
          else                  next_state = ST_STOPPING;
        end else if (fall && burst_hit) begin
          next_state = ST_IDLE;
        end
      end
      ST_STOPPING: begin
        if (fall) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign leave_run  = (state != ST_IDLE) && (next_state == ST_IDLE);
  // Clearing on entry to IDLE also swallows a rise that would coincide with
  // an abort from the low phase.
  assign core_clear = (next_state == ST_IDLE);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      active_div   <= CNT_W'(1);
      active_burst <= '0;
      shadow_div   <= '0;
      shadow_burst <= '0;
      pending      <= 1'b0;
      burst_cnt    <= '0;
      armed        <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= next_state;
      done  <= leave_run;
      armed <= (state != ST_IDLE) && (next_state != ST_IDLE);

      if (state == ST_IDLE) begin
        burst_cnt <= '0;
        if (cfg_valid) begin
          active_div   <= cfg_div;
          active_burst <= cfg_burst;
        end
      end else begin
        if (rise && !core_clear && (burst_cnt != {BURST_W{1'b1}}))
          burst_cnt <= burst_cnt + BURST_W'(1);

        if (pending && (fall || leave_run)) begin
          active_div   <= shadow_div;
          active_burst <= shadow_burst;
          pending      <= 1'b0;
        end else if (cfg_valid && !pending) begin
          if (leave_run) begin
            // Nothing left to protect: the new values take effect directly.
            active_div   <= cfg_div;
            active_burst <= cfg_burst;
          end else begin
            shadow_div   <= cfg_div;
            shadow_burst <= cfg_burst;
            pending      <= 1'b1;
          end
        end
      end
    end
  end

  prescaler_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (core_en),
    .clear   (core_clear),
    .div     (div_eff),
    .clk_out (clk_out),
    .tick    (tick),
    .rise    (rise),
    .fall    (fall)
  );

endmodule

`default_nettype wire
